cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Coprocessor-0 exception sequencer for the pipelined MIPS core. It is the producer and consumer of the exception program counter. It detects exceptions and interrupts at the MEM stage, records the faulting PC, Cause and Status, flushes the pipeline and redirects fetch to the handler vector. On `eret` it reads EPC back and redirects fetch to it. It owns the Status (12), Cause (13) and EPC (14) registers and serves `mtc0`/`mfc0` accesses to them.

## Interface
Parameters:
- VECTOR, 32'h0000_0004, handler entry address driven on `redirect_pc` when an exception is taken.

Ports:
- clk  in  1  core clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- exc_ov  in  1  arithmetic overflow from the MEM-stage instruction.
- exc_ri  in  1  reserved-instruction exception from the MEM-stage instruction.
- exc_sys  in  1  `syscall` in MEM.
- exc_pc  in  32  PC of the MEM-stage instruction; this is the EPC value for all causes.
- int_in  in  6  external interrupt lines, level-sensitive; they map to Cause.IP[15:10].
- eret  in  1  `eret` in MEM.
- mtc0_we  in  1  `mtc0` write strobe from the MEM stage.
- mtc0_addr  in  5  CP0 register number for the write.
- mtc0_data  in  32  write data.
- mfc0_addr  in  5  CP0 register number for the read.
- mfc0_data  out  32  combinational read data; unimplemented registers read 0.
- busy  out  1  high whenever the sequencer is not in IDLE; the hazard unit stalls IF and ID while it is high.
- flush  out  1  kills the IF, ID, EX and MEM pipeline registers.
- redirect  out  1  the PC mux selects `redirect_pc`.
- redirect_pc  out  32  target PC.

## Operation
Registers:
- Status: IM[15:8], EXL[1] and IE[0] are read/write; all other bits read 0.
- Cause: IP[15:10] is read-only and is sampled from `int_in` every cycle. ExcCode[6:2] is read-only. All other bits read 0.
- EPC: 32 bits, read/write.

Take condition, evaluated only in IDLE:
- A synchronous exception is pending if any of `exc_ov`, `exc_ri`, `exc_sys` is high.
- An interrupt is pending if IE=1, EXL=0 and (Cause.IP & Status.IM[15:10]) != 0.
- Priority, highest first: ov (ExcCode 12), ri (10), sys (8), interrupt (0).

State machine with states IDLE, FLUSH, VECTOR and ERET:
- IDLE to FLUSH when a take condition holds. On that edge: EPC<=exc_pc, ExcCode<=code of the winning cause, EXL<=1.
- IDLE to ERET when `eret`=1 and no take condition holds.
- FLUSH to VECTOR unconditionally. In FLUSH: flush=1.
- VECTOR to IDLE. In VECTOR: redirect=1, redirect_pc=VECTOR.
- ERET to IDLE. In ERET: flush=1, redirect=1, redirect_pc=current EPC. EXL<=0 on the exit edge.

Interactions and ignored inputs:
- An exception and `eret` in the same cycle: the exception wins and `eret` is dropped.
- `mtc0` to Status or EPC is applied only in IDLE, and only when no take condition holds; otherwise the exception update wins and the write is discarded.
- `mtc0` to Cause or to any unimplemented number is ignored.
- Exception, `eret` and `mtc0` inputs arriving outside IDLE are ignored; the flush kills their source instructions.
- `mfc0_data` reflects register contents before the current edge. There is no internal bypass; forwarding is the pipeline's job.

## Timing
- Reset: every register clears to 0 asynchronously, including IP. The state goes to IDLE and busy, flush, redirect and redirect_pc are all 0.
- Exception latency, with take condition seen in cycle T:
  - flush=1 in T+1.
  - redirect=1 with VECTOR in T+2.
  - busy=1 during T+1 and T+2; back in IDLE at T+3.
- `eret` latency, with `eret` seen in cycle T:
  - flush=1 and redirect=1 together in T+1.
  - EXL reads 0 from T+2.
- Reset deasserted mid-sequence: the machine restarts in IDLE and no redirect is emitted.
- An interrupt line that drops before the IDLE sample is not taken; there is no edge latching.
- Back-to-back exceptions: a new exception can be taken in the first IDLE cycle after VECTOR.

## Test plan
- Overflow: exc_ov=1, exc_pc=0x0000_0040 in IDLE -> EPC=0x40, ExcCode=12 and EXL=1 at T+1; flush in T+1; redirect_pc=0x4 in T+2.
- Priority: exc_ov=exc_sys=1 together with a masked-in interrupt -> ExcCode=12 and exactly one flush/vector sequence.
- Interrupt gating: int_in=6'b000001 with IM[10]=1:
  - IE=0 -> no take.
  - IE=1, EXL=0 -> ExcCode=0 and EPC=exc_pc.
  - EXL=1 -> no take.
- Eret round trip: `mtc0` EPC=0x0000_1234, then `eret` -> flush and redirect with 0x1234 in T+1, and EXL=0 afterwards.
- Collisions:
  - `mtc0` EPC=0xFFFF_0000 in the same cycle as exc_sys with exc_pc=0x80 -> EPC=0x80.
  - `eret` in the same cycle as exc_ri -> RI sequence only.
- Reset: pull rst_n low during FLUSH -> all outputs 0 immediately, no redirect afterwards, and `mfc0` of registers 12, 13 and 14 returns 0.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
// Coprocessor-0 exception sequencer. Exceptions and interrupts are detected at
// the MEM stage. When one is taken, the block records EPC, the Cause ExcCode and
// Status.EXL, flushes the pipeline and then redirects fetch to VECTOR. An eret
// flushes the pipeline and redirects fetch to EPC in one cycle. The block owns
// the Status (12), Cause (13) and EPC (14) registers and serves mtc0/mfc0
// accesses to them.
//
// Ports
//   clk, rst_n          core clock; asynchronous active-low reset
//   exc_ov/ri/sys       synchronous exception flags from the MEM-stage instruction
//   exc_pc              PC of the MEM-stage instruction (the EPC for every cause)
//   int_in[5:0]         level-sensitive interrupt lines, sampled into Cause.IP
//   eret                eret in MEM
//   mtc0_we/addr/data   CP0 write port
//   mfc0_addr/data      CP0 read port (combinational, no bypass)
//   busy                sequencer is not idle (the hazard unit stalls IF/ID)
//   flush               kills the IF, ID, EX and MEM pipeline registers
//   redirect            PC mux selects redirect_pc
//   redirect_pc         redirect target
//
// Outputs are Moore outputs decoded from the state register. Exception path:
// IDLE -> FLUSH -> VECT -> IDLE. Eret path: IDLE -> ERET -> IDLE.
module cp0_exc_ctrl #(
    parameter logic [31:0] VECTOR = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_ov,
    input  logic        exc_ri,
    input  logic        exc_sys,
    input  logic [31:0] exc_pc,
    input  logic [5:0]  int_in,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_data,
    output logic        busy,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_VECT  = 2'd2,
        S_ERET  = 2'd3
    } state_t;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    state_t      state, state_next;

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic [5:0]  cause_ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        idle;
    logic        exc_pend;
    logic        int_pend;
    logic        take;
    logic        eret_go;
    logic [4:0]  code_next;

    // Write-data bits with no backing Status bit.
    logic        unused_ok;
    assign unused_ok = ^{mtc0_data[31:16], mtc0_data[7:2]};

    assign idle     = (state == S_IDLE);
    assign exc_pend = exc_ov | exc_ri | exc_sys;
    // Interrupts use the registered IP, so a line must still be high when IP
    // is sampled. No edge is latched.
    assign int_pend = status_ie & ~status_exl & (|(cause_ip & status_im[7:2]));
    assign take     = idle & (exc_pend | int_pend);
    assign eret_go  = idle & eret & ~take;

    always_comb begin
        code_next = 5'd0;
        if (exc_ov)       code_next = 5'd12;
        else if (exc_ri)  code_next = 5'd10;
        else if (exc_sys) code_next = 5'd8;
        else              code_next = 5'd0;
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        case (state)
            S_IDLE: begin
                if (take)         state_next = S_FLUSH;
                else if (eret_go) state_next = S_ERET;
            end
            S_FLUSH: begin
                busy       = 1'b1;
                flush      = 1'b1;
                state_next = S_VECT;
            end
            S_VECT: begin
                busy        = 1'b1;
                redirect    = 1'b1;
                redirect_pc = VECTOR;
                state_next  = S_IDLE;
            end
            S_ERET: begin
                busy        = 1'b1;
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = epc;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CP0 register file. The exception update has priority over mtc0, and
    // nothing except IP sampling changes outside IDLE apart from the
    // clearing of EXL when ERET exits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_im  <= 8'h0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
            cause_ip   <= 6'h0;
            exc_code   <= 5'h0;
            epc        <= 32'h0;
        end else begin
            cause_ip <= int_in;
            if (take) begin
                epc        <= exc_pc;
                exc_code   <= code_next;
                status_exl <= 1'b1;
            end else if (idle && mtc0_we) begin
                if (mtc0_addr == REG_STATUS) begin
                    status_im  <= mtc0_data[15:8];
                    status_exl <= mtc0_data[1];
                    status_ie  <= mtc0_data[0];
                end else if (mtc0_addr == REG_EPC) begin
                    epc <= mtc0_data;
                end
            end
            if (state == S_ERET) begin
                status_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        mfc0_data = 32'h0;
        case (mfc0_addr)
            REG_STATUS: mfc0_data = {16'h0, status_im, 6'h0, status_exl, status_ie};
            REG_CAUSE:  mfc0_data = {16'h0, cause_ip, 3'h0, exc_code, 2'h0};
            REG_EPC:    mfc0_data = epc;
            default:    mfc0_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        exc_ov, exc_ri, exc_sys;
    logic [31:0] exc_pc;
    logic [5:0]  int_in;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_data;
    logic        busy, flush, redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    cp0_exc_ctrl #(.VECTOR(32'h0000_0004)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_ov(exc_ov), .exc_ri(exc_ri), .exc_sys(exc_sys), .exc_pc(exc_pc),
        .int_in(int_in), .eret(eret),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
        .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
        .busy(busy), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per cycle: inputs driven after the rising edge; outputs and the
    // read port are compared at the falling edge of the same cycle.
    typedef struct {
        string       name;
        logic        ov, ri, sys;
        logic [31:0] pc;
        logic [5:0]  intr;
        logic        er;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic        b, f, r;
        logic [31:0] rpc;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic ov, logic ri, logic sys, logic [31:0] pc,
                                logic [5:0] intr, logic er, logic we, logic [4:0] wa,
                                logic [31:0] wd, logic [4:0] ra, logic b, logic f,
                                logic r, logic [31:0] rpc, logic [31:0] rd);
        vec_t v;
        v.name = nm; v.ov = ov; v.ri = ri; v.sys = sys; v.pc = pc; v.intr = intr;
        v.er = er; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra;
        v.b = b; v.f = f; v.r = r; v.rpc = rpc; v.rd = rd;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        exc_ov = 0; exc_ri = 0; exc_sys = 0; exc_pc = 32'h0; int_in = 6'h0;
        eret = 0; mtc0_we = 0; mtc0_addr = 5'd0; mtc0_data = 32'h0; mfc0_addr = 5'd0;
    endtask

    task automatic apply(vec_t v);
        exc_ov = v.ov; exc_ri = v.ri; exc_sys = v.sys; exc_pc = v.pc; int_in = v.intr;
        eret = v.er; mtc0_we = v.we; mtc0_addr = v.wa; mtc0_data = v.wd; mfc0_addr = v.ra;
        @(negedge clk);
        check({v.name, ".busy"},        {31'h0, busy},     {31'h0, v.b});
        check({v.name, ".flush"},       {31'h0, flush},    {31'h0, v.f});
        check({v.name, ".redirect"},    {31'h0, redirect}, {31'h0, v.r});
        check({v.name, ".redirect_pc"}, redirect_pc,       v.rpc);
        check({v.name, ".mfc0"},        mfc0_data,         v.rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //      name      ov ri sy pc          int  er we wa  wd            ra   b f r rpc     rd
        tbl.push_back(mk("rst12",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h0));
        tbl.push_back(mk("rst13",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd13,0,0,0,32'h0,  32'h0));
        tbl.push_back(mk("rst14",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd14,0,0,0,32'h0,  32'h0));
        // Overflow at PC 0x40
        tbl.push_back(mk("ov_t",   1,0,0,32'h40, 6'h0,0,0,5'd0, 32'h0,        5'd14,0,0,0,32'h0,  32'h0));
        tbl.push_back(mk("ov_t1",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd14,1,1,0,32'h0,  32'h40));
        tbl.push_back(mk("ov_t2",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd13,1,0,1,32'h4,  32'h30));
        tbl.push_back(mk("ov_t3",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h2));
        // Status: IM[10]=1, IE=1, EXL=0; raise int line 0
        tbl.push_back(mk("st_wr",  0,0,0,32'h0,  6'h1,0,1,5'd12,32'h401,      5'd12,0,0,0,32'h0,  32'h2));
        // ov+sys+interrupt together: ov wins
        tbl.push_back(mk("pri_t",  1,0,1,32'h100,6'h1,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h401));
        tbl.push_back(mk("pri_t1", 0,0,0,32'h0,  6'h1,0,0,5'd0, 32'h0,        5'd13,1,1,0,32'h0,  32'h430));
        tbl.push_back(mk("pri_t2", 0,0,0,32'h0,  6'h1,0,0,5'd0, 32'h0,        5'd14,1,0,1,32'h4,  32'h100));
        // EXL=1 blocks the still-pending interrupt
        tbl.push_back(mk("exl_a",  0,0,0,32'h0,  6'h1,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h403));
        tbl.push_back(mk("exl_b",  0,0,0,32'h0,  6'h1,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h403));
        // IE=0 blocks the interrupt
        tbl.push_back(mk("ie0_wr", 0,0,0,32'h0,  6'h1,0,1,5'd12,32'h400,      5'd12,0,0,0,32'h0,  32'h403));
        tbl.push_back(mk("ie0_a",  0,0,0,32'h0,  6'h1,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h400));
        tbl.push_back(mk("ie0_b",  0,0,0,32'h0,  6'h1,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h400));
        // IE=1, EXL=0: interrupt taken with EPC=exc_pc and ExcCode 0
        tbl.push_back(mk("ie1_wr", 0,0,0,32'h0,  6'h1,0,1,5'd12,32'h401,      5'd12,0,0,0,32'h0,  32'h400));
        tbl.push_back(mk("int_t",  0,0,0,32'h200,6'h1,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h401));
        tbl.push_back(mk("int_t1", 0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd14,1,1,0,32'h0,  32'h200));
        tbl.push_back(mk("int_t2", 0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd13,1,0,1,32'h4,  32'h0));
        tbl.push_back(mk("int_t3", 0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h403));
        // eret round trip
        tbl.push_back(mk("epc_wr", 0,0,0,32'h0,  6'h0,0,1,5'd14,32'h1234,     5'd14,0,0,0,32'h0,  32'h200));
        tbl.push_back(mk("eret_t", 0,0,0,32'h0,  6'h0,1,0,5'd0, 32'h0,        5'd14,0,0,0,32'h0,  32'h1234));
        tbl.push_back(mk("eret_t1",0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd12,1,1,1,32'h1234,32'h403));
        tbl.push_back(mk("eret_t2",0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h401));
        // mtc0 EPC collides with syscall: exception wins
        tbl.push_back(mk("col_t",  0,0,1,32'h80, 6'h0,0,1,5'd14,32'hFFFF_0000,5'd14,0,0,0,32'h0,  32'h1234));
        tbl.push_back(mk("col_t1", 0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd14,1,1,0,32'h0,  32'h80));
        tbl.push_back(mk("col_t2", 0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd13,1,0,1,32'h4,  32'h20));
        tbl.push_back(mk("col_t3", 0,0,0,32'h0,  6'h0,0,1,5'd12,32'h401,      5'd12,0,0,0,32'h0,  32'h403));
        // eret collides with RI: only the RI sequence runs
        tbl.push_back(mk("ri_t",   0,1,0,32'h300,6'h0,1,0,5'd0, 32'h0,        5'd14,0,0,0,32'h0,  32'h80));
        tbl.push_back(mk("ri_t1",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd14,1,1,0,32'h0,  32'h300));
        tbl.push_back(mk("ri_t2",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd13,1,0,1,32'h4,  32'h28));
        tbl.push_back(mk("ri_t3",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h403));
        tbl.push_back(mk("ri_t4",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'h403));
        // Cause is not writable; unimplemented registers read 0
        tbl.push_back(mk("cause_wr",0,0,0,32'h0, 6'h0,0,1,5'd13,32'hFFFF_FFFF,5'd5, 0,0,0,32'h0,  32'h0));
        tbl.push_back(mk("cause_rd",0,0,0,32'h0, 6'h0,0,0,5'd0, 32'h0,        5'd13,0,0,0,32'h0,  32'h28));
        // Only IM, EXL and IE of Status are writable
        tbl.push_back(mk("st_all", 0,0,0,32'h0,  6'h0,0,1,5'd12,32'hFFFF_FFFF,5'd12,0,0,0,32'h0,  32'h403));
        tbl.push_back(mk("st_rd",  0,0,0,32'h0,  6'h0,0,0,5'd0, 32'h0,        5'd12,0,0,0,32'h0,  32'hFF03));

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Reset asserted while the machine is in FLUSH
        drive_idle();
        exc_ov = 1'b1; exc_pc = 32'h500;
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        check("rst_mid.flush_before", {31'h0, flush}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid.busy",        {31'h0, busy},     32'h0);
        check("rst_mid.flush",       {31'h0, flush},    32'h0);
        check("rst_mid.redirect",    {31'h0, redirect}, 32'h0);
        check("rst_mid.redirect_pc", redirect_pc,       32'h0);
        mfc0_addr = 5'd12; #1; check("rst_mid.status", mfc0_data, 32'h0);
        mfc0_addr = 5'd13; #1; check("rst_mid.cause",  mfc0_data, 32'h0);
        mfc0_addr = 5'd14; #1; check("rst_mid.epc",    mfc0_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_after.redirect", {31'h0, redirect}, 32'h0);
            check("rst_after.busy",     {31'h0, busy},     32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
